// File: rtl/multicycle_control_if.sv
// Shared instruction/data memory port between the control sequencer (master)
// and the memory (slave): request, write strobe, address select and ready.
interface multicycle_control_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr_sel,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr_sel,
      output mem_ready
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control sequencer for the 16-bit datapath: walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives every datapath select and enable.
module multicycle_control #(
   parameter int RETIRE_W = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   multicycle_control_if.master      mem,
   input  logic [15:0]               inst,
   input  logic                      branch_taken,
   output logic [2:0]                state,
   output logic                      ir_write,
   output logic                      pc_write,
   output logic [1:0]                pc_src,
   output logic                      imm_en,
   output logic [1:0]                alu_src_b,
   output logic [1:0]                alu_op,
   output logic                      reg_write,
   output logic [1:0]                wb_sel,
   output logic                      halted,
   output logic                      illegal,
   output logic [RETIRE_W-1:0]       retired
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5,
      ST_TRAP   = 3'd6
   } state_t;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ITYPE = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_STORE = 4'h3;
   localparam logic [3:0] OP_BEQ   = 4'h4;
   localparam logic [3:0] OP_JAL   = 4'h5;
   localparam logic [3:0] OP_HALT  = 4'hF;

   state_t                state_q, state_d;
   logic                  halted_q, halted_d;
   logic                  illegal_q, illegal_d;
   logic [RETIRE_W-1:0]   retired_q, retired_d;
   logic                  retire_inc;
   logic [3:0]            opcode;

   assign opcode = inst[3:0];

   // Immediate/function fields belong to the datapath, not to sequencing.
   logic unused_inst_fields;
   assign unused_inst_fields = ^inst[15:4];

   always_comb begin
      state_d          = state_q;
      retire_inc       = 1'b0;
      mem.mem_req      = 1'b0;
      mem.mem_we       = 1'b0;
      mem.mem_addr_sel = 1'b0;
      ir_write         = 1'b0;
      pc_write         = 1'b0;
      pc_src           = 2'd0;
      imm_en           = 1'b0;
      alu_src_b        = 2'd0;
      alu_op           = 2'd0;
      reg_write        = 1'b0;
      wb_sel           = 2'd0;

      case (state_q)
         ST_FETCH: begin
            mem.mem_req = 1'b1;
            if (mem.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = ST_DECODE;
            end
         end
         ST_DECODE: begin
            imm_en = 1'b1;
            if (opcode <= OP_JAL) begin
               state_d = ST_EXEC;
            end else if (opcode == OP_HALT) begin
               state_d    = ST_HALT;
               retire_inc = 1'b1;
            end else begin
               state_d = ST_TRAP;
            end
         end
         ST_EXEC: begin
            case (opcode)
               OP_RTYPE: begin
                  alu_op  = 2'd3;
                  state_d = ST_WB;
               end
               OP_ITYPE: begin
                  alu_src_b = 2'd1;
                  state_d   = ST_WB;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_b = 2'd1;
                  state_d   = ST_MEM;
               end
               OP_BEQ: begin
                  alu_op     = 2'd1;
                  pc_src     = 2'd2;
                  pc_write   = branch_taken;
                  state_d    = ST_FETCH;
                  retire_inc = 1'b1;
               end
               OP_JAL: begin
                  reg_write  = 1'b1;
                  wb_sel     = 2'd2;
                  pc_write   = 1'b1;
                  pc_src     = 2'd2;
                  state_d    = ST_FETCH;
                  retire_inc = 1'b1;
               end
               // Only reachable if inst changed after DECODE.
               default: state_d = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            mem.mem_req      = 1'b1;
            mem.mem_addr_sel = 1'b1;
            mem.mem_we       = (opcode == OP_STORE);
            if (mem.mem_ready) begin
               if (opcode == OP_STORE) begin
                  state_d    = ST_FETCH;
                  retire_inc = 1'b1;
               end else begin
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            reg_write  = 1'b1;
            wb_sel     = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
            state_d    = ST_FETCH;
            retire_inc = 1'b1;
         end
         ST_HALT, ST_TRAP: state_d = state_q;
         default: state_d = ST_FETCH;
      endcase

      // While reset is held nothing may be written or requested.
      if (!reset) begin
         mem.mem_req      = 1'b0;
         mem.mem_we       = 1'b0;
         mem.mem_addr_sel = 1'b0;
         ir_write         = 1'b0;
         pc_write         = 1'b0;
         pc_src           = 2'd0;
         imm_en           = 1'b0;
         alu_src_b        = 2'd0;
         alu_op           = 2'd0;
         reg_write        = 1'b0;
         wb_sel           = 2'd0;
      end

      halted_d  = halted_q  | (state_d == ST_HALT);
      illegal_d = illegal_q | (state_d == ST_TRAP);
      retired_d = retired_q + RETIRE_W'(retire_inc);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_FETCH;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   assign state   = state_q;
   assign halted  = halted_q;
   assign illegal = illegal_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: the driver plans each instruction cycle by cycle from the
// opcode rules and queues the expected outputs; a monitor compares every cycle.
module tb_multicycle_control;
   localparam int RW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [15:0]   inst = 16'h0000;
   logic          branch_taken = 1'b0;
   logic [2:0]    state;
   logic          ir_write, pc_write, imm_en, reg_write, halted, illegal;
   logic [1:0]    pc_src, alu_src_b, alu_op, wb_sel;
   logic [RW-1:0] retired;

   multicycle_control_if bus();

   multicycle_control #(.RETIRE_W(RW)) dut (
      .clock(clock), .reset(reset), .mem(bus), .inst(inst),
      .branch_taken(branch_taken), .state(state), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .imm_en(imm_en),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
      .wb_sel(wb_sel), .halted(halted), .illegal(illegal), .retired(retired)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [2:0]    state;
      logic          mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
      logic [1:0]    pc_src;
      logic          imm_en;
      logic [1:0]    alu_src_b, alu_op;
      logic          reg_write;
      logic [1:0]    wb_sel;
      logic          halted, illegal;
      logic [RW-1:0] retired;
   } ctl_t;

   typedef struct {
      ctl_t  ctl;
      bit    last;
      string name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   retired_m = 0;

   function automatic ctl_t base_ctl(input logic [2:0] st);
      ctl_t c;
      c = '0;
      c.state   = st;
      c.retired = RW'(retired_m);
      c.halted  = (st == 3'd5);
      c.illegal = (st == 3'd6);
      return c;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // One planned cycle: drive mem_ready, queue the expectation, advance.
   task automatic cyc(input ctl_t c, input bit rdy, input bit last, input string name);
      exp_t e;
      bus.mem_ready = rdy;
      e.ctl = c; e.last = last; e.name = name;
      exp_q.push_back(e);
      @(negedge clock);
   endtask

   task automatic run_instr(input logic [15:0] ins, input int wf, input int wm,
                            input bit bt, input int tail);
      ctl_t  c;
      logic [3:0] op;
      string nm;
      op = ins[3:0];
      inst = ins;
      branch_taken = bt;
      nm = $sformatf("inst=%h wf=%0d wm=%0d bt=%0d", ins, wf, wm, bt);
      for (int i = 0; i < wf; i++) begin
         c = base_ctl(3'd0); c.mem_req = 1'b1;
         cyc(c, 1'b0, 1'b0, nm);
      end
      c = base_ctl(3'd0); c.mem_req = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
      cyc(c, 1'b1, 1'b0, nm);
      c = base_ctl(3'd1); c.imm_en = 1'b1;
      cyc(c, 1'($urandom_range(0, 1)), (op > 4'h5), nm);
      if (op <= 4'h5) begin
         c = base_ctl(3'd2);
         case (op)
            4'h0: c.alu_op = 2'd3;
            4'h1, 4'h2, 4'h3: c.alu_src_b = 2'd1;
            4'h4: begin c.alu_op = 2'd1; c.pc_src = 2'd2; c.pc_write = bt; end
            default: begin
               c.reg_write = 1'b1; c.wb_sel = 2'd2; c.pc_write = 1'b1; c.pc_src = 2'd2;
            end
         endcase
         cyc(c, 1'($urandom_range(0, 1)), (op >= 4'h4), nm);
         if (op == 4'h2 || op == 4'h3) begin
            c = base_ctl(3'd3); c.mem_req = 1'b1; c.mem_addr_sel = 1'b1;
            c.mem_we = (op == 4'h3);
            for (int i = 0; i < wm; i++) cyc(c, 1'b0, 1'b0, nm);
            cyc(c, 1'b1, (op == 4'h3), nm);
         end
         if (op <= 4'h2) begin
            c = base_ctl(3'd4); c.reg_write = 1'b1; c.wb_sel = (op == 4'h2) ? 2'd1 : 2'd0;
            cyc(c, 1'($urandom_range(0, 1)), 1'b1, nm);
         end
      end
      if (op <= 4'h5 || op == 4'hF) retired_m = (retired_m + 1) % (1 << RW);
      for (int i = 0; i < tail; i++) begin
         c = base_ctl((op == 4'hF) ? 3'd5 : 3'd6);
         cyc(c, 1'($urandom_range(0, 1)), 1'b0, nm);
      end
   endtask

   // Monitor: one comparison of the full control vector per planned cycle.
   exp_t mon_e;
   ctl_t mon_a;
   always @(negedge clock) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_a = {state, bus.mem_req, bus.mem_we, bus.mem_addr_sel, ir_write, pc_write,
                  pc_src, imm_en, alu_src_b, alu_op, reg_write, wb_sel, halted,
                  illegal, retired};
         checks++;
         if (mon_a !== mon_e.ctl) begin
            errors++;
            $display("FAIL ctl %s actual=%h required=%h", mon_e.name, mon_a, mon_e.ctl);
         end
         if (mon_e.last) $display("txn %s retired=%0d", mon_e.name, retired);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] op;
      bus.mem_ready = 1'b1;
      #2;
      chk("rst_state", 32'(state), 0);
      chk("rst_mem_req", 32'(bus.mem_req), 0);
      chk("rst_retired", 32'(retired), 0);
      @(negedge clock);
      #2;
      chk("rst_hold_state", 32'(state), 0);
      chk("rst_hold_writes", {30'd0, ir_write, pc_write}, 0);
      chk("rst_sticky", {30'd0, halted, illegal}, 0);
      @(negedge clock);
      reset = 1'b1;

      repeat (3) run_instr(16'h0000, 0, 0, 1'b0, 0);
      run_instr(16'h9602, 2, 1, 1'b0, 0);
      run_instr(16'h0104, 0, 0, 1'b1, 0);
      run_instr(16'h0104, 0, 0, 1'b0, 0);
      run_instr(16'h1235, 1, 0, 1'b0, 0);
      run_instr(16'h4413, 0, 2, 1'b0, 0);
      run_instr(16'h2221, 3, 0, 1'b0, 0);

      // Long random run also carries the retired counter through its wrap.
      for (int n = 0; n < 300; n++) begin
         op = 4'($urandom_range(0, 5));
         run_instr({12'($urandom), op}, $urandom_range(0, 2), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), 0);
      end

      run_instr(16'h000F, 0, 0, 1'b0, 10);
      chk("halt_mem_req", 32'(bus.mem_req), 0);
      #3 reset = 1'b0;
      #1;
      chk("async_rst_state", 32'(state), 0);
      chk("async_rst_halted", 32'(halted), 0);
      chk("async_rst_retired", 32'(retired), 0);
      @(negedge clock);
      reset = 1'b1;
      retired_m = 0;

      run_instr(16'h0007, 1, 0, 1'b0, 6);
      chk("trap_retired", 32'(retired), 0);
      #3 reset = 1'b0;
      #1;
      chk("async_rst_trap_state", 32'(state), 0);
      chk("async_rst_illegal", 32'(illegal), 0);
      @(negedge clock);
      reset = 1'b1;
      retired_m = 0;
      run_instr(16'h0000, 0, 0, 1'b0, 0);
      run_instr(16'h0002, 1, 1, 1'b0, 0);

      #2;
      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control sequencer for the 16-bit processor datapath. Takes the instruction register contents and sequences fetch, decode, execute, memory and writeback. Drives every datapath select and enable: PC/IR write, ALU operand and op selects, immediate-generator enable, register-file write, writeback mux and memory request. Sits beside the datapath (register file, ALU, imm_gen_component, PC) and talks to a single shared instruction/data memory port through a req/ready handshake.

## Interface
- RETIRE_W, 16, width of retired-instruction counter

- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low forces reset state immediately
- inst  in  16  current IR contents; opcode = inst[3:0], immediate field = inst[15:8]
- branch_taken  in  1  ALU compare result, valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, valid with mem_req
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_write  out  1  load IR from memory data
- pc_write  out  1  update PC
- pc_src  out  2  0 = PC+2, 1 = ALU result, 2 = branch target register
- imm_en  out  1  enable imm_gen_component output register
- alu_src_b  out  2  0 = rs2, 1 = immediate, 2 = constant 2
- alu_op  out  2  0 = add, 1 = sub, 2 = pass B, 3 = decoded from inst[7:4]
- reg_write  out  1  register-file write enable
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC (link)
- halted  out  1  sticky, HALT state reached
- illegal  out  1  sticky, unknown opcode decoded
- retired  out  RETIRE_W  count of completed instructions

## Operation
- Opcodes: 0 R-type ALU, 1 I-type ALU, 2 load, 3 store, 4 branch-equal, 5 jal, F halt; 6–E illegal.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0; hold until mem_ready=1; in that cycle ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE: imm_en=1; all other enables 0. Next: 0–5 to EXEC, F to HALT, else to TRAP.
- EXEC: R-type alu_src_b=0, alu_op=3, to WB. I-type/load/store alu_src_b=1, alu_op=0; I-type to WB, load/store to MEM. Branch alu_op=1, alu_src_b=0, pc_src=2, pc_write=branch_taken, to FETCH. Jal: reg_write=1, wb_sel=2, pc_write=1, pc_src=2, to FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for store; hold until mem_ready. Store then goes to FETCH; load goes to WB.
- WB: reg_write=1, wb_sel=1 for load, else 0; to FETCH.
- HALT, TRAP: absorbing. All enables 0. halted and illegal stay 1 until reset.
- retired increments by 1 on the last cycle of each completed instruction. Halt counts on entering HALT; trap does not count. Wraps from all-ones to 0.
- Default for any output not listed in a state: 0.

## Timing
- Outputs are Moore (decoded from state), except ir_write/pc_write in FETCH, mem_we qualifiers and pc_write in branch EXEC. These are combinational from mem_ready / branch_taken.
- Reset values: state=FETCH, retired=0, halted=0, illegal=0, all enables 0. mem_req=1 and mem_addr_sel=0 one delta after reset deasserts, because the FETCH decode is active.
- Reset asserted mid-instruction: state returns to FETCH asynchronously; no writes occur. Any pending mem request is abandoned; memory must tolerate mem_req dropping without ready.
- Zero-wait latency (mem_ready tied 1): branch/jal 3 cycles, R/I-type/store 4, load 5. Each wait cycle on mem_ready adds one cycle in FETCH or MEM.
- mem_ready outside FETCH/MEM is ignored.
- inst must be stable from DECODE through the instruction's last state.

## Test plan
- Reset low at t=0, release; mem_ready=1, inst=16'h0000 stream -> states 0,1,2,4 repeat; retired increments every 4 cycles; reg_write high only in WB.
- Load inst=16'h9602 with 2 wait cycles in FETCH and 1 in MEM -> FETCH lasts 3 cycles, MEM 2, WB wb_sel=1; total 8 cycles; retired +1.
- Branch inst=16'h0104, branch_taken=1 then 0 -> pc_write=1, pc_src=2 in EXEC for first; pc_write=0 in EXEC for second; each is 3 cycles.
- inst=16'h000F -> DECODE then HALT; halted=1, retired+1, mem_req stays 0 indefinitely.
- inst=16'h0007 -> TRAP; illegal=1, retired unchanged. Then reset low -> state=0, illegal=0 immediately, without waiting for a clock.
- Preload retired near all-ones (force, or 65535 R-type ops) -> next completion reads 16'h0000.
